// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control for the 5-stage OTTER core: stall/flush/forward/redirect.
// Define HAZ_PERF_CNT_EN to build the retired/stall performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] rs1_D,
  input  logic [REG_ADDR_W-1:0] rs2_D,
  input  logic [REG_ADDR_W-1:0] rd_D,
  input  logic                  use_rs1_D,
  input  logic                  use_rs2_D,
  input  logic                  regWrite_D,
  input  logic                  load_D,
  input  logic                  ex_busy_E,
  input  logic                  pcSource_E,
  input  logic                  mem_req_M,
  input  logic                  mem_ready_M,
  output logic                  stall_F,
  output logic                  stall_D,
  output logic                  stall_E,
  output logic                  stall_M,
  output logic                  flush_D,
  output logic                  flush_E,
  output logic                  flush_M,
  output logic                  flush_W,
  output logic [1:0]            forwardA_E,
  output logic [1:0]            forwardB_E,
  output logic                  pc_redirect,
  output logic                  valid_E,
  output logic                  valid_M,
  output logic                  valid_W,
  output logic [CNT_W-1:0]      retired_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic                  r_valid_D;
  logic                  r_valid_E, r_use1_E, r_use2_E, r_rw_E, r_ld_E;
  logic [REG_ADDR_W-1:0] r_rd_E, r_rs1_E, r_rs2_E;
  logic                  r_valid_M, r_rw_M, r_ld_M;
  logic [REG_ADDR_W-1:0] r_rd_M;
  logic                  r_valid_W, r_rw_W;
  logic [REG_ADDR_W-1:0] r_rd_W;

  logic w_memw, w_exw, w_redir, w_lu, w_lu_dep, w_fwd_M_ok, w_fwd_W_ok;

  // Each hazard term masks every lower-priority one, so at most one acts.
  assign w_memw   = r_valid_M & mem_req_M & ~mem_ready_M;
  assign w_exw    = ~w_memw & r_valid_E & ex_busy_E;
  assign w_redir  = ~w_memw & ~w_exw & r_valid_E & pcSource_E;
  assign w_lu_dep = (use_rs1_D & (rs1_D == r_rd_E)) | (use_rs2_D & (rs2_D == r_rd_E));
  assign w_lu     = ~w_memw & ~w_exw & ~w_redir & r_valid_D & r_valid_E & r_ld_E &
                    (r_rd_E != '0) & w_lu_dep;

  assign stall_F     = w_memw | w_exw | w_lu;
  assign stall_D     = w_memw | w_exw | w_lu;
  assign stall_E     = w_memw | w_exw;
  assign stall_M     = w_memw;
  assign flush_D     = w_redir;
  assign flush_E     = w_redir | w_lu;
  assign flush_M     = w_exw;
  assign flush_W     = w_memw;
  assign pc_redirect = w_redir;

  assign valid_E = r_valid_E;
  assign valid_M = r_valid_M;
  assign valid_W = r_valid_W;

  // Load data is not ready in M; the load-use bubble keeps this path unused.
  assign w_fwd_M_ok = r_valid_M & r_rw_M & ~r_ld_M & (r_rd_M != '0);
  assign w_fwd_W_ok = r_valid_W & r_rw_W & (r_rd_W != '0);

  always_comb begin
    forwardA_E = 2'b00;
    forwardB_E = 2'b00;
    if (r_use1_E & w_fwd_M_ok & (r_rs1_E == r_rd_M))      forwardA_E = 2'b01;
    else if (r_use1_E & w_fwd_W_ok & (r_rs1_E == r_rd_W)) forwardA_E = 2'b10;
    if (r_use2_E & w_fwd_M_ok & (r_rs2_E == r_rd_M))      forwardB_E = 2'b01;
    else if (r_use2_E & w_fwd_W_ok & (r_rs2_E == r_rd_W)) forwardB_E = 2'b10;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)        r_valid_D <= 1'b0;
    else if (flush_D) r_valid_D <= 1'b0;
    else if (!stall_F) r_valid_D <= 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET || flush_E) begin
      r_valid_E <= 1'b0;
      r_rd_E    <= '0;
      r_rs1_E   <= '0;
      r_rs2_E   <= '0;
      r_use1_E  <= 1'b0;
      r_use2_E  <= 1'b0;
      r_rw_E    <= 1'b0;
      r_ld_E    <= 1'b0;
    end else if (!stall_E) begin
      r_valid_E <= r_valid_D;
      r_rd_E    <= rd_D;
      r_rs1_E   <= rs1_D;
      r_rs2_E   <= rs2_D;
      r_use1_E  <= use_rs1_D;
      r_use2_E  <= use_rs2_D;
      r_rw_E    <= regWrite_D;
      r_ld_E    <= load_D;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET || flush_M) begin
      r_valid_M <= 1'b0;
      r_rd_M    <= '0;
      r_rw_M    <= 1'b0;
      r_ld_M    <= 1'b0;
    end else if (!stall_M) begin
      r_valid_M <= r_valid_E;
      r_rd_M    <= r_rd_E;
      r_rw_M    <= r_rw_E;
      r_ld_M    <= r_ld_E;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET || flush_W) begin
      r_valid_W <= 1'b0;
      r_rd_W    <= '0;
      r_rw_W    <= 1'b0;
    end else begin
      r_valid_W <= r_valid_M;
      r_rd_W    <= r_rd_M;
      r_rw_W    <= r_rw_M;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_retired_cnt, r_stall_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (r_valid_W & ~flush_W) r_retired_cnt <= r_retired_cnt + CNT_W'(1);
      if (stall_F)              r_stall_cnt   <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign retired_cnt = r_retired_cnt;
  assign stall_cnt   = r_stall_cnt;
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, reset corner case, and
// randomized traffic checked against a stage-shift reference model.
module tb_pipe_hazard_ctrl;

  logic        CLK, RESET;
  logic [4:0]  rs1_D, rs2_D, rd_D;
  logic        use_rs1_D, use_rs2_D, regWrite_D, load_D;
  logic        ex_busy_E, pcSource_E, mem_req_M, mem_ready_M;
  logic        stall_F, stall_D, stall_E, stall_M;
  logic        flush_D, flush_E, flush_M, flush_W;
  logic [1:0]  forwardA_E, forwardB_E;
  logic        pc_redirect, valid_E, valid_M, valid_W;
  logic [31:0] retired_cnt, stall_cnt;
  logic [15:0] obs;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
    .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .regWrite_D(regWrite_D), .load_D(load_D),
    .ex_busy_E(ex_busy_E), .pcSource_E(pcSource_E),
    .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E), .pc_redirect(pc_redirect),
    .valid_E(valid_E), .valid_M(valid_M), .valid_W(valid_W),
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  assign obs = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W,
                forwardA_E, forwardB_E, pc_redirect, valid_E, valid_M, valid_W};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic [3:0] dfl;  // use_rs1 use_rs2 regWrite load
    logic [3:0] ctl;  // ex_busy pcSource mem_req mem_ready
    logic [3:0] st;   // stall F D E M
    logic [3:0] fl;   // flush D E M W
    logic [1:0] fa, fb;
    logic       pr;
    logic [2:0] vv;   // valid E M W
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rs1, rs2, rd, input logic [3:0] dfl, ctl,
                              input logic [3:0] st, fl, input logic [1:0] fa, fb,
                              input logic pr, input logic [2:0] vv);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.dfl = dfl; v.ctl = ctl;
    v.st = st; v.fl = fl; v.fa = fa; v.fb = fb; v.pr = pr; v.vv = vv;
    return v;
  endfunction

  task automatic drive(input logic [4:0] rs1, rs2, rd, input logic [3:0] dfl, ctl);
    rs1_D = rs1; rs2_D = rs2; rd_D = rd;
    {use_rs1_D, use_rs2_D, regWrite_D, load_D} = dfl;
    {ex_busy_E, pcSource_E, mem_req_M, mem_ready_M} = ctl;
  endtask

  // Reference model: instruction records per stage, shifted by the hazard event.
  typedef struct packed {
    logic       v;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, rw, ld;
  } ins_t;
  typedef enum int {EV_NONE, EV_MEMW, EV_EXW, EV_REDIR, EV_LU} ev_t;

  ins_t        mE, mM, mW;
  logic        m_vD;
  int unsigned m_ret, m_stall;

  function automatic logic [1:0] fsel(input logic [4:0] r, input logic u);
    if (u && mM.v && mM.rw && !mM.ld && mM.rd != 0 && mM.rd == r) return 2'b01;
    if (u && mW.v && mW.rw && mW.rd != 0 && mW.rd == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic ev_t hazard();
    if (mM.v && mem_req_M && !mem_ready_M) return EV_MEMW;
    if (mE.v && ex_busy_E) return EV_EXW;
    if (mE.v && pcSource_E) return EV_REDIR;
    if (m_vD && mE.v && mE.ld && mE.rd != 0 &&
        ((use_rs1_D && rs1_D == mE.rd) || (use_rs2_D && rs2_D == mE.rd))) return EV_LU;
    return EV_NONE;
  endfunction

  function automatic logic [15:0] model_obs(input ev_t ev);
    logic [8:0] c;
    case (ev)
      EV_MEMW:  c = {4'b1111, 4'b0001, 1'b0};
      EV_EXW:   c = {4'b1110, 4'b0010, 1'b0};
      EV_REDIR: c = {4'b0000, 4'b1100, 1'b1};
      EV_LU:    c = {4'b1100, 4'b0100, 1'b0};
      default:  c = '0;
    endcase
    return {c[8:1], fsel(mE.rs1, mE.u1), fsel(mE.rs2, mE.u2), c[0], mE.v, mM.v, mW.v};
  endfunction

  task automatic model_reset();
    mE = '0; mM = '0; mW = '0; m_vD = 1'b0; m_ret = 0; m_stall = 0;
  endtask

  task automatic model_step(input ev_t ev);
    ins_t din;
    din = {m_vD, rd_D, rs1_D, rs2_D, use_rs1_D, use_rs2_D, regWrite_D, load_D};
    if (mW.v && ev != EV_MEMW) m_ret++;
    if (ev == EV_MEMW || ev == EV_EXW || ev == EV_LU) m_stall++;
    case (ev)
      EV_MEMW:  mW = '0;
      EV_EXW:   begin mW = mM; mM = '0; end
      EV_LU:    begin mW = mM; mM = mE; mE = '0; end
      EV_REDIR: begin mW = mM; mM = mE; mE = '0; m_vD = 1'b0; end
      default:  begin mW = mM; mM = mE; mE = din; m_vD = 1'b1; end
    endcase
  endtask

  vec_t        tbl[26];
  int unsigned e_ret, e_stall, m_exp_ret, m_exp_stall;

  initial begin
    RESET = 1'b1;
    drive(0, 0, 0, 4'b0000, 4'b0000);
    // c1-c3 load-use; c4-c8 forwarding incl. x0; c9 redirect beats load-use;
    // c13-c16 memory wait with pending branch; c19-c22 multi-cycle execute.
    tbl[0]  = mk(0, 0, 0,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 0, 3'b000);
    tbl[1]  = mk(1, 0, 5,  4'b1011, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 0, 3'b000);
    tbl[2]  = mk(5, 7, 6,  4'b1110, 4'b0000, 4'b1100, 4'b0100, 2'b00, 2'b00, 0, 3'b100);
    tbl[3]  = mk(5, 7, 6,  4'b1110, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 0, 3'b010);
    tbl[4]  = mk(0, 0, 5,  4'b1010, 4'b0000, 4'b0000, 4'b0000, 2'b10, 2'b00, 0, 3'b101);
    tbl[5]  = mk(5, 5, 8,  4'b1110, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 0, 3'b110);
    tbl[6]  = mk(0, 0, 0,  4'b1010, 4'b0000, 4'b0000, 4'b0000, 2'b01, 2'b01, 0, 3'b111);
    tbl[7]  = mk(0, 0, 8,  4'b1110, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 0, 3'b111);
    tbl[8]  = mk(1, 2, 9,  4'b1111, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 0, 3'b111);
    tbl[9]  = mk(9, 0, 10, 4'b1010, 4'b0100, 4'b0000, 4'b1100, 2'b00, 2'b00, 1, 3'b111);
    tbl[10] = mk(0, 0, 0,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 0, 3'b011);
    tbl[11] = mk(1, 2, 0,  4'b1100, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 0, 3'b001);
    tbl[12] = mk(3, 4, 0,  4'b1100, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 0, 3'b100);
    for (int unsigned i = 13; i < 16; i++)
      tbl[i] = mk(0, 0, 11, 4'b1010, 4'b0110, 4'b1111, 4'b0001, 2'b00, 2'b00, 0, 3'b110);
    tbl[16] = mk(0, 0, 11, 4'b1010, 4'b0111, 4'b0000, 4'b1100, 2'b00, 2'b00, 1, 3'b110);
    tbl[17] = mk(0, 0, 0,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 0, 3'b011);
    tbl[18] = mk(1, 0, 12, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 0, 3'b001);
    for (int unsigned i = 19; i < 23; i++)
      tbl[i] = mk(12, 0, 13, 4'b1110, 4'b1000, 4'b1110, 4'b0010, 2'b00, 2'b00, 0, 3'b100);
    tbl[23] = mk(12, 0, 13, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 0, 3'b100);
    tbl[24] = mk(12, 13, 15, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 2'b01, 2'b00, 0, 3'b110);
    tbl[25] = mk(0, 0, 0,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b10, 2'b01, 0, 3'b111);

    @(negedge CLK);
    chk("reset_outputs", obs, 16'h0000);
    @(negedge CLK);
    RESET = 1'b0;

    e_ret = 0; e_stall = 0;
    for (int unsigned i = 0; i < 26; i++) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].dfl, tbl[i].ctl);
      #1;
      chk($sformatf("vec%0d", i), obs,
          {tbl[i].st, tbl[i].fl, tbl[i].fa, tbl[i].fb, tbl[i].pr, tbl[i].vv});
      if (tbl[i].st[3]) e_stall++;
      if (tbl[i].vv[0] && !tbl[i].fl[0]) e_ret++;
      @(negedge CLK);
    end
`ifdef HAZ_PERF_CNT_EN
    chk("retired_cnt_dir", retired_cnt, e_ret);
    chk("stall_cnt_dir", stall_cnt, e_stall);
`else
    chk("retired_cnt_tied", retired_cnt, 0);
    chk("stall_cnt_tied", stall_cnt, 0);
`endif

    // Reset pulse in the middle of a memory wait.
    drive(0, 0, 0, 4'b0000, 4'b0110);
    #1;
    chk("memw_before_reset", obs, {4'b1111, 4'b0001, 2'b00, 2'b00, 1'b0, 3'b111});
    #1 RESET = 1'b1;
    #1;
    chk("reset_mid_memw", obs, 16'h0000);
    chk("reset_retired", retired_cnt, 0);
    chk("reset_stall", stall_cnt, 0);
    @(negedge CLK);
    RESET = 1'b0;
    drive(0, 0, 0, 4'b0000, 4'b0100);
    #1;
    chk("no_redirect_after_reset", obs, 16'h0000);
    @(negedge CLK);
    #1;
    chk("first_cycle_after_reset", obs, 16'h0000);
    drive(0, 0, 0, 4'b0000, 4'b0000);
    @(negedge CLK);
    #1;
    chk("valid_E_after_reset", obs, 16'h0004);

    // Randomized traffic against the reference model.
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    begin
      ev_t ev;
      ev = EV_NONE;
      for (int unsigned i = 0; i < 3000; i++) begin
        if (ev == EV_NONE || ev == EV_REDIR) begin
          if (m_vD)
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 4'b0000);
          else
            drive(0, 0, 0, 4'b0000, 4'b0000);
        end
        ex_busy_E   = ($urandom_range(0, 9) < 2);
        pcSource_E  = ($urandom_range(0, 9) < 2);
        mem_req_M   = 1'($urandom_range(0, 1));
        mem_ready_M = ($urandom_range(0, 9) < 6);
        #1;
        ev = hazard();
        chk("rand_outputs", obs, model_obs(ev));
`ifdef HAZ_PERF_CNT_EN
        m_exp_ret = m_ret; m_exp_stall = m_stall;
`else
        m_exp_ret = 0; m_exp_stall = 0;
`endif
        chk("rand_retired_cnt", retired_cnt, m_exp_ret);
        chk("rand_stall_cnt", stall_cnt, m_exp_stall);
        model_step(ev);
        @(negedge CLK);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
